seg_scan_driver: RTL

// Downstream consumer of the 3-bit digit-select counter. Drives an 8-digit multiplexed
// 7-segment display: hex-decodes the selected nibble, drives one anode at a time, and

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Bundle of the scan-driver stimulus and display outputs shared between
// the digit scanner side (master) and the segment driver (slave).
interface seg_scan_if;
  logic [2:0]  digit_sel;
  logic        value_load;
  logic [31:0] value_in;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_suppress;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        update_pending;

  modport master (
    output digit_sel, value_load, value_in, dp_in, digit_en, lz_suppress,
    input  an, seg, dp, update_pending
  );

  modport slave (
    input  digit_sel, value_load, value_in, dp_in, digit_en, lz_suppress,
    output an, seg, dp, update_pending
  );
endinterface

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed 7-segment driver: hex decode, one-hot anode drive,
// anti-ghost blanking between digits and frame-atomic shadow/active commit.
module seg_scan_driver #(
  parameter int BLANK_CYCLES = 4,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave bus
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [7:0] BLANK_INIT   = 8'(BLANK_CYCLES);
  localparam logic [7:0] BLANK_RELOAD = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;
  localparam logic [7:0] AN_OFF       = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF      = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF       = ACTIVE_LOW;

  // Segment pattern {g,f,e,d,c,b,a}, high-true; b and d are lowercase glyphs.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'h3F;
      4'h1:    hex7 = 7'h06;
      4'h2:    hex7 = 7'h5B;
      4'h3:    hex7 = 7'h4F;
      4'h4:    hex7 = 7'h66;
      4'h5:    hex7 = 7'h6D;
      4'h6:    hex7 = 7'h7D;
      4'h7:    hex7 = 7'h07;
      4'h8:    hex7 = 7'h7F;
      4'h9:    hex7 = 7'h6F;
      4'hA:    hex7 = 7'h77;
      4'hB:    hex7 = 7'h7C;
      4'hC:    hex7 = 7'h39;
      4'hD:    hex7 = 7'h5E;
      4'hE:    hex7 = 7'h79;
      4'hF:    hex7 = 7'h71;
      default: hex7 = 7'h00;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [2:0]  sel_r;
  logic [31:0] shadow_val_r, active_val_r;
  logic [7:0]  shadow_dp_r, active_dp_r;
  logic        pending_r;
  logic [7:0]  an_r, an_s;
  logic [6:0]  seg_r, seg_s;
  logic        dp_r, dp_s;
  logic        change_s, wrap_s;
  logic [7:0]  nib_zero_s, zero_above_s;
  logic [3:0]  nib_s;
  logic        suppress_s;

  assign change_s = (bus.digit_sel != sel_r);
  assign wrap_s   = change_s && (bus.digit_sel < sel_r);

  // Blanking FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_BLANK;
      cnt_r   <= BLANK_INIT;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state: any digit change restarts the full blank interval
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (change_s) begin
      if (BLANK_CYCLES == 0) begin
        state_s = ST_DRIVE;
        cnt_s   = 8'd0;
      end else begin
        state_s = ST_BLANK;
        cnt_s   = BLANK_RELOAD;
      end
    end else begin
      case (state_r)
        ST_BLANK: begin
          if (cnt_r == 8'd0) begin
            state_s = ST_DRIVE;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end
        ST_DRIVE: state_s = ST_DRIVE;
        default: begin
          state_s = ST_BLANK;
          cnt_s   = BLANK_INIT;
        end
      endcase
    end
  end

  // Select register plus shadow/active display data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r        <= 3'd0;
      shadow_val_r <= 32'd0;
      shadow_dp_r  <= 8'd0;
      active_val_r <= 32'd0;
      active_dp_r  <= 8'd0;
      pending_r    <= 1'b0;
    end else begin
      sel_r <= bus.digit_sel;
      if (bus.value_load && wrap_s) begin
        shadow_val_r <= bus.value_in;
        shadow_dp_r  <= bus.dp_in;
        active_val_r <= bus.value_in;
        active_dp_r  <= bus.dp_in;
        pending_r    <= 1'b0;
      end else if (bus.value_load) begin
        shadow_val_r <= bus.value_in;
        shadow_dp_r  <= bus.dp_in;
        pending_r    <= 1'b1;
      end else if (wrap_s) begin
        active_val_r <= shadow_val_r;
        active_dp_r  <= shadow_dp_r;
        pending_r    <= 1'b0;
      end
    end
  end

  // Leading-zero detect: bit k set when nibbles k..7 of active are all zero
  always_comb begin
    nib_zero_s   = 8'd0;
    zero_above_s = 8'd0;
    for (int k = 0; k < 8; k++) begin
      nib_zero_s[k] = (active_val_r[4*k +: 4] == 4'd0);
    end
    for (int k = 0; k < 8; k++) begin
      zero_above_s[k] = &(nib_zero_s | 8'((8'd1 << k) - 8'd1));
    end
  end

  assign nib_s      = active_val_r[{sel_r, 2'b00} +: 4];
  assign suppress_s = !bus.digit_en[sel_r] ||
                      (bus.lz_suppress && (sel_r != 3'd0) && zero_above_s[sel_r]);

  // Drive values for the next output edge
  always_comb begin
    an_s  = AN_OFF;
    seg_s = SEG_OFF;
    dp_s  = DP_OFF;
    if ((state_r == ST_DRIVE) && !suppress_s) begin
      an_s  = AN_OFF ^ 8'(8'd1 << sel_r);
      seg_s = SEG_OFF ^ hex7(nib_s);
      dp_s  = DP_OFF ^ active_dp_r[sel_r];
    end else begin
      an_s  = AN_OFF;
      seg_s = SEG_OFF;
      dp_s  = DP_OFF;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= DP_OFF;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign bus.an             = an_r;
  assign bus.seg            = seg_r;
  assign bus.dp             = dp_r;
  assign bus.update_pending = pending_r;

endmodule
